// File: rtl/rob_pkg.sv
// rtl/rob_pkg.sv - shared types and helpers for the multi-wide reorder buffer
package rob_pkg;

  localparam int ROB_XLEN         = 32;
  localparam int ROB_REG_ADDR_LEN = 5;

  typedef struct packed {
    logic                        valid;
    logic                        ready;
    logic                        mispred;
    logic [ROB_REG_ADDR_LEN-1:0] dst_reg;
    logic [ROB_XLEN-1:0]         data;
    logic [ROB_XLEN-1:0]         tpc;
  } rob_entry_t;

  function automatic int rob_tag_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// rtl/rob_commit_sel.sv - head-relative prefix scan selecting retiring lanes
module rob_commit_sel #(
  parameter int COMMIT_W = 2,
  parameter int CNT_W    = $clog2(COMMIT_W + 1),
  parameter int LANE_W   = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1
) (
  input  logic [COMMIT_W-1:0] win_rdy_i,
  input  logic [COMMIT_W-1:0] win_mispred_i,
  output logic [COMMIT_W-1:0] cmt_valid_o,
  output logic [CNT_W-1:0]    retire_cnt_o,
  output logic                flush_o,
  output logic [LANE_W-1:0]   flush_lane_o
);

  logic go;

  // A mispredicted entry retires itself but blocks every younger lane.
  always_comb begin
    cmt_valid_o  = '0;
    retire_cnt_o = '0;
    flush_o      = 1'b0;
    flush_lane_o = '0;
    go           = 1'b1;
    for (int i = 0; i < COMMIT_W; i++) begin
      if (go && win_rdy_i[i]) begin
        cmt_valid_o[i] = 1'b1;
        retire_cnt_o   = CNT_W'(i + 1);
        if (win_mispred_i[i]) begin
          flush_o      = 1'b1;
          flush_lane_o = LANE_W'(i);
          go           = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/reorder_buffer_mw.sv
// rtl/reorder_buffer_mw.sv - multi-wide reorder buffer; ROB_CDB_BYPASS_EN adds CDB-to-search bypass
module reorder_buffer_mw
  import rob_pkg::*;
#(
  parameter int ROB_DEPTH    = 16,
  parameter int DISPATCH_W   = 2,
  parameter int COMMIT_W     = 2,
  parameter int CDB_W        = 2,
  parameter int XLEN         = ROB_XLEN,
  parameter int REG_ADDR_LEN = ROB_REG_ADDR_LEN
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [DISPATCH_W-1:0]                  disp_valid,
  input  logic [DISPATCH_W*REG_ADDR_LEN-1:0]     disp_reg,
  output logic                                   disp_ready,
  output logic [DISPATCH_W*rob_tag_w(ROB_DEPTH)-1:0] disp_tag,
  input  logic [CDB_W-1:0]                       cdb_valid,
  input  logic [CDB_W*rob_tag_w(ROB_DEPTH)-1:0]  cdb_tag,
  input  logic [CDB_W*XLEN-1:0]                  cdb_data,
  input  logic [CDB_W*XLEN-1:0]                  cdb_tpc,
  input  logic [CDB_W-1:0]                       cdb_mispred,
  input  logic [2*DISPATCH_W*rob_tag_w(ROB_DEPTH)-1:0] srch_tag,
  output logic [2*DISPATCH_W-1:0]                srch_ready,
  output logic [2*DISPATCH_W*XLEN-1:0]           srch_data,
  output logic [COMMIT_W-1:0]                    cmt_valid,
  output logic [COMMIT_W*REG_ADDR_LEN-1:0]       cmt_reg,
  output logic [COMMIT_W*XLEN-1:0]               cmt_data,
  output logic                                   flush,
  output logic [XLEN-1:0]                        flush_pc,
  output logic                                   rob_empty,
  output logic [rob_tag_w(ROB_DEPTH):0]          rob_count
);

  localparam int TAG_W  = rob_tag_w(ROB_DEPTH);
  localparam int CNT_W  = TAG_W + 1;
  localparam int DCNT_W = $clog2(DISPATCH_W + 1);
  localparam int RCNT_W = $clog2(COMMIT_W + 1);
  localparam int LANE_W = (COMMIT_W > 1) ? $clog2(COMMIT_W) : 1;

  rob_entry_t        rob_q [ROB_DEPTH];
  rob_entry_t        rob_d [ROB_DEPTH];
  logic [TAG_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [COMMIT_W-1:0] win_rdy, win_mispred;
  logic [RCNT_W-1:0]   retire_cnt;
  logic [LANE_W-1:0]   flush_lane;
  logic                disp_fire;
  logic [DCNT_W-1:0]   disp_n;

  always_comb begin
    win_rdy     = '0;
    win_mispred = '0;
    cmt_reg     = '0;
    cmt_data    = '0;
    for (int i = 0; i < COMMIT_W; i++) begin
      win_rdy[i]     = rob_q[head_q + TAG_W'(i)].valid & rob_q[head_q + TAG_W'(i)].ready;
      win_mispred[i] = rob_q[head_q + TAG_W'(i)].mispred;
      cmt_reg[i*REG_ADDR_LEN +: REG_ADDR_LEN] = rob_q[head_q + TAG_W'(i)].dst_reg;
      cmt_data[i*XLEN +: XLEN]                = rob_q[head_q + TAG_W'(i)].data;
    end
  end

  rob_commit_sel #(
    .COMMIT_W (COMMIT_W),
    .CNT_W    (RCNT_W),
    .LANE_W   (LANE_W)
  ) u_commit_sel (
    .win_rdy_i     (win_rdy),
    .win_mispred_i (win_mispred),
    .cmt_valid_o   (cmt_valid),
    .retire_cnt_o  (retire_cnt),
    .flush_o       (flush),
    .flush_lane_o  (flush_lane)
  );

  assign flush_pc   = flush ? rob_q[head_q + TAG_W'(flush_lane)].tpc : '0;
  assign rob_count  = count_q;
  assign rob_empty  = (count_q == '0);
  // Readiness deliberately ignores this cycle's retirements: no lookahead.
  assign disp_ready = (CNT_W'(ROB_DEPTH) - count_q) >= CNT_W'(DISPATCH_W);
  assign disp_fire  = disp_ready & (|disp_valid);
  assign disp_n     = disp_fire ? DCNT_W'($countones(disp_valid)) : '0;

  always_comb begin
    disp_tag = '0;
    for (int i = 0; i < DISPATCH_W; i++)
      disp_tag[i*TAG_W +: TAG_W] = tail_q + TAG_W'(i);
  end

  always_comb begin
    rob_d   = rob_q;
    head_d  = head_q + TAG_W'(retire_cnt);
    tail_d  = tail_q + TAG_W'(disp_n);
    count_d = count_q + CNT_W'(disp_n) - CNT_W'(retire_cnt);
    for (int i = 0; i < COMMIT_W; i++)
      if (cmt_valid[i]) rob_d[head_q + TAG_W'(i)].valid = 1'b0;
    for (int i = 0; i < DISPATCH_W; i++)
      if (disp_fire && disp_valid[i])
        rob_d[tail_q + TAG_W'(i)] = '{valid: 1'b1, ready: 1'b0, mispred: 1'b0,
                                      dst_reg: disp_reg[i*REG_ADDR_LEN +: REG_ADDR_LEN],
                                      data: '0, tpc: '0};
    // Later channels overwrite earlier ones on a duplicate tag.
    for (int c = 0; c < CDB_W; c++)
      if (cdb_valid[c]) begin
        rob_d[cdb_tag[c*TAG_W +: TAG_W]].ready   = 1'b1;
        rob_d[cdb_tag[c*TAG_W +: TAG_W]].data    = cdb_data[c*XLEN +: XLEN];
        rob_d[cdb_tag[c*TAG_W +: TAG_W]].tpc     = cdb_tpc[c*XLEN +: XLEN];
        rob_d[cdb_tag[c*TAG_W +: TAG_W]].mispred = cdb_mispred[c];
      end
    if (flush) begin
      for (int e = 0; e < ROB_DEPTH; e++) rob_d[e] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int e = 0; e < ROB_DEPTH; e++) rob_q[e] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      rob_q   <= rob_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    srch_ready = '0;
    srch_data  = '0;
    for (int s = 0; s < 2*DISPATCH_W; s++) begin
      if (rob_q[srch_tag[s*TAG_W +: TAG_W]].valid && rob_q[srch_tag[s*TAG_W +: TAG_W]].ready) begin
        srch_ready[s]            = 1'b1;
        srch_data[s*XLEN +: XLEN] = rob_q[srch_tag[s*TAG_W +: TAG_W]].data;
      end
`ifdef ROB_CDB_BYPASS_EN
      for (int c = 0; c < CDB_W; c++)
        if (cdb_valid[c] && (cdb_tag[c*TAG_W +: TAG_W] == srch_tag[s*TAG_W +: TAG_W])) begin
          srch_ready[s]            = 1'b1;
          srch_data[s*XLEN +: XLEN] = cdb_data[c*XLEN +: XLEN];
        end
`else
`endif
    end
  end

  a_disp_contig: assert property (@(posedge clk) disable iff (reset)
    (disp_valid & (disp_valid + DISPATCH_W'(1))) == '0);

endmodule

// File: tb/tb_reorder_buffer_mw.sv
// tb/tb_reorder_buffer_mw.sv - self-checking bench: directed table, corner sequences, random vs queue model
module tb_reorder_buffer_mw;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   disp_valid;
  logic [9:0]   disp_reg;
  logic         disp_ready;
  logic [7:0]   disp_tag;
  logic [1:0]   cdb_valid;
  logic [7:0]   cdb_tag;
  logic [63:0]  cdb_data;
  logic [63:0]  cdb_tpc;
  logic [1:0]   cdb_mispred;
  logic [15:0]  srch_tag;
  logic [3:0]   srch_ready;
  logic [127:0] srch_data;
  logic [1:0]   cmt_valid;
  logic [9:0]   cmt_reg;
  logic [63:0]  cmt_data;
  logic         flush;
  logic [31:0]  flush_pc;
  logic         rob_empty;
  logic [4:0]   rob_count;

  int checks = 0;
  int errors = 0;

  reorder_buffer_mw dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_reg(disp_reg), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data), .cdb_tpc(cdb_tpc),
    .cdb_mispred(cdb_mispred), .srch_tag(srch_tag), .srch_ready(srch_ready), .srch_data(srch_data),
    .cmt_valid(cmt_valid), .cmt_reg(cmt_reg), .cmt_data(cmt_data), .flush(flush),
    .flush_pc(flush_pc), .rob_empty(rob_empty), .rob_count(rob_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  typedef struct {
    logic [1:0]  dv;
    logic [1:0]  cv;
    logic [7:0]  ct;
    logic [63:0] cd;
    logic        e_rdy;
    logic [7:0]  e_tag;
    logic [1:0]  e_cmt;
    logic [4:0]  e_cnt;
    logic [9:0]  e_creg;
    logic [63:0] e_cdat;
  } vec_t;
  vec_t vec [14];

  typedef struct {
    int          tag;
    logic [4:0]  rd;
    logic        rdy;
    logic        mp;
    logic [31:0] data;
    logic [31:0] tpc;
  } ment_t;
  ment_t mq[$];
  int    m_next_tag;
  int    m_k;
  logic  m_flush;
  logic  m_rdy;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_in();
    disp_valid = '0; disp_reg = '0; cdb_valid = '0; cdb_tag = '0;
    cdb_data = '0; cdb_tpc = '0; cdb_mispred = '0; srch_tag = '0;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mq.delete();
    m_next_tag = 0;
  endtask

  task automatic model_check();
    logic [1:0]  ecv;
    logic        ef;
    logic [31:0] efpc;
    logic [7:0]  etag;
    bit          stop;
    m_rdy = (16 - mq.size()) >= 2;
    chk("rnd_ready", disp_ready, m_rdy);
    etag = {4'((m_next_tag + 1) % 16), 4'(m_next_tag)};
    chk("rnd_tag", disp_tag, etag);
    ecv = '0; ef = 1'b0; efpc = '0; stop = 0; m_k = 0;
    for (int i = 0; i < 2; i++) begin
      if (!stop && i < mq.size() && mq[i].rdy) begin
        ecv[i] = 1'b1;
        m_k++;
        chk("rnd_cmt_reg", cmt_reg[i*5 +: 5], mq[i].rd);
        chk("rnd_cmt_data", cmt_data[i*32 +: 32], mq[i].data);
        if (mq[i].mp) begin
          ef = 1'b1; efpc = mq[i].tpc; stop = 1;
        end
      end else begin
        stop = 1;
      end
    end
    m_flush = ef;
    chk("rnd_cmt_valid", cmt_valid, ecv);
    chk("rnd_flush", flush, ef);
    chk("rnd_flush_pc", flush_pc, efpc);
    chk("rnd_count", rob_count, 5'(mq.size()));
    chk("rnd_empty", rob_empty, mq.size() == 0);
    for (int s = 0; s < 4; s++) begin
      logic [3:0]  t;
      logic        er;
      logic [31:0] ed;
      t = srch_tag[s*4 +: 4]; er = 1'b0; ed = '0;
      foreach (mq[j]) if (mq[j].tag == int'(t) && mq[j].rdy) begin er = 1'b1; ed = mq[j].data; end
`ifdef ROB_CDB_BYPASS_EN
      for (int c = 0; c < 2; c++)
        if (cdb_valid[c] && cdb_tag[c*4 +: 4] == t) begin er = 1'b1; ed = cdb_data[c*32 +: 32]; end
`endif
      chk("rnd_srch_ready", srch_ready[s], er);
      chk("rnd_srch_data", srch_data[s*32 +: 32], ed);
    end
  endtask

  task automatic model_step(input int n);
    ment_t e;
    repeat (m_k) mq.delete(0);
    if (m_flush) begin
      mq.delete();
      m_next_tag = 0;
      return;
    end
    for (int c = 0; c < 2; c++)
      if (cdb_valid[c])
        foreach (mq[j])
          if (mq[j].tag == int'(cdb_tag[c*4 +: 4])) begin
            mq[j].rdy = 1'b1; mq[j].data = cdb_data[c*32 +: 32];
            mq[j].tpc = cdb_tpc[c*32 +: 32]; mq[j].mp = cdb_mispred[c];
          end
    if (m_rdy)
      for (int i = 0; i < n; i++) begin
        e.tag = m_next_tag; e.rd = disp_reg[i*5 +: 5]; e.rdy = 1'b0;
        e.mp = 1'b0; e.data = '0; e.tpc = '0;
        mq.push_back(e);
        m_next_tag = (m_next_tag + 1) % 16;
      end
  endtask

  initial begin
    int n;
    int w;
    int cands[$];

    for (int r = 0; r < 14; r++) begin
      vec[r] = '{default: 0};
      vec[r].e_tag = 8'h10;
    end
    for (int r = 0; r < 8; r++) begin
      vec[r].dv = 2'b11; vec[r].e_rdy = 1'b1;
      vec[r].e_tag = {4'(2*r+1), 4'(2*r)}; vec[r].e_cnt = 5'(2*r);
    end
    vec[8].e_cnt = 16;
    vec[9].cv = 2'b01;  vec[9].ct = 8'h01;  vec[9].cd = 64'h11;  vec[9].e_cnt = 16;
    vec[10].e_cnt = 16;
    vec[11].cv = 2'b01; vec[11].ct = 8'h00; vec[11].cd = 64'h10; vec[11].e_cnt = 16;
    vec[12].e_cnt = 16; vec[12].e_cmt = 2'b11;
    vec[12].e_creg = {5'd1, 5'd0}; vec[12].e_cdat = {32'h11, 32'h10};
    vec[13].e_rdy = 1'b1; vec[13].e_cnt = 14;

    // Reset state
    do_reset();
    #1;
    chk("rst_empty", rob_empty, 1'b1);
    chk("rst_ready", disp_ready, 1'b1);
    chk("rst_tag", disp_tag, 8'h10);
    chk("rst_cmt", cmt_valid, 2'b00);
    chk("rst_flush", flush, 1'b0);
    chk("rst_count", rob_count, 5'd0);

    // Table: fill, out-of-order completion, in-order double commit
    for (int r = 0; r < 14; r++) begin
      clr_in();
      disp_valid = vec[r].dv;
      disp_reg   = {5'(2*r+1), 5'(2*r)};
      cdb_valid  = vec[r].cv;
      cdb_tag    = vec[r].ct;
      cdb_data   = vec[r].cd;
      #1;
      chk("tbl_ready", disp_ready, vec[r].e_rdy);
      chk("tbl_tag", disp_tag, vec[r].e_tag);
      chk("tbl_cmt", cmt_valid, vec[r].e_cmt);
      chk("tbl_count", rob_count, vec[r].e_cnt);
      if (vec[r].e_cmt != 2'b00) begin
        chk("tbl_cmt_reg", cmt_reg, vec[r].e_creg);
        chk("tbl_cmt_data", cmt_data, vec[r].e_cdat);
      end
      tick();
    end

    // Mispredict flush with a younger ready entry and a discarded dispatch
    do_reset();
    disp_valid = 2'b11; disp_reg = {5'd1, 5'd0};
    tick();
    clr_in();
    cdb_valid = 2'b11; cdb_tag = {4'd1, 4'd0}; cdb_mispred = 2'b01;
    cdb_tpc = {32'h0, 32'h400}; cdb_data = {32'h6, 32'h5};
    tick();
    clr_in();
    disp_valid = 2'b11;
    #1;
    chk("fl_cmt", cmt_valid, 2'b01);
    chk("fl_flush", flush, 1'b1);
    chk("fl_pc", flush_pc, 32'h400);
    chk("fl_reg", cmt_reg[4:0], 5'd0);
    tick();
    clr_in();
    #1;
    chk("fl_count", rob_count, 5'd0);
    chk("fl_empty", rob_empty, 1'b1);
    chk("fl_tag", disp_tag, 8'h10);
    chk("fl_cmt_after", cmt_valid, 2'b00);

    // Wrap: fill, retire 14, dispatch 4
    do_reset();
    for (int r = 0; r < 8; r++) begin
      disp_valid = 2'b11; disp_reg = {5'(2*r+1), 5'(2*r)};
      tick();
    end
    clr_in();
    for (int r = 0; r < 7; r++) begin
      cdb_valid = 2'b11; cdb_tag = {4'(2*r+1), 4'(2*r)};
      cdb_data = {32'(256 + 2*r + 1), 32'(256 + 2*r)};
      tick();
    end
    clr_in();
    w = 0;
    while (rob_count != 5'd2 && w < 20) begin
      tick();
      w++;
    end
    chk("wrap_drain", rob_count, 5'd2);
    disp_valid = 2'b11; disp_reg = {5'd17, 5'd16};
    #1;
    chk("wrap_ready", disp_ready, 1'b1);
    chk("wrap_tag0", disp_tag, 8'h10);
    tick();
    disp_valid = 2'b11; disp_reg = {5'd19, 5'd18};
    #1;
    chk("wrap_tag1", disp_tag, 8'h32);
    tick();
    clr_in();
    #1;
    chk("wrap_count", rob_count, 5'd6);
    cdb_valid = 2'b11; cdb_tag = {4'd15, 4'd14};
    tick();
    clr_in();
    #1;
    chk("wrap_head_cmt", cmt_valid, 2'b11);
    chk("wrap_head_reg", cmt_reg, {5'd15, 5'd14});
    tick();

    // Search with same-cycle CDB on tag 5
    do_reset();
    for (int r = 0; r < 3; r++) begin
      disp_valid = 2'b11; disp_reg = {5'(2*r+1), 5'(2*r)};
      tick();
    end
    clr_in();
    srch_tag = 16'h0005; cdb_valid = 2'b01; cdb_tag = 8'h05; cdb_data = 64'hABCD;
    #1;
`ifdef ROB_CDB_BYPASS_EN
    chk("byp_ready", srch_ready[0], 1'b1);
    chk("byp_data", srch_data[31:0], 32'hABCD);
`else
    chk("byp_ready", srch_ready[0], 1'b0);
    chk("byp_data", srch_data[31:0], 32'h0);
`endif
    tick();
    clr_in();
    srch_tag = 16'h0005;
    #1;
    chk("srch_ready_next", srch_ready[0], 1'b1);
    chk("srch_data_next", srch_data[31:0], 32'hABCD);
    tick();

    // Reset mid-operation overrides dispatch and completion
    clr_in();
    reset = 1'b1; disp_valid = 2'b11; cdb_valid = 2'b11; cdb_tag = {4'd1, 4'd0};
    tick();
    reset = 1'b0;
    clr_in();
    #1;
    chk("mrst_count", rob_count, 5'd0);
    chk("mrst_empty", rob_empty, 1'b1);
    chk("mrst_tag", disp_tag, 8'h10);
    chk("mrst_cmt", cmt_valid, 2'b00);

    // Random traffic against the queue model
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      clr_in();
      n = $urandom_range(0, 2);
      disp_valid = (n == 2) ? 2'b11 : (n == 1) ? 2'b01 : 2'b00;
      disp_reg = 10'($urandom);
      cands.delete();
      foreach (mq[j]) if (!mq[j].rdy && $urandom_range(0, 2) == 0) cands.push_back(mq[j].tag);
      for (int c = 0; c < 2; c++)
        if (c < cands.size()) begin
          cdb_valid[c] = 1'b1;
          cdb_tag[c*4 +: 4] = 4'(cands[c]);
          cdb_data[c*32 +: 32] = $urandom;
          cdb_tpc[c*32 +: 32] = $urandom;
          cdb_mispred[c] = ($urandom_range(0, 7) == 0);
        end
      srch_tag = 16'($urandom);
      #1;
      model_check();
      model_step(n);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
